blink_64_dec_ctrl: RTL and testbench

//  Request-side controller that runs the round-based Blink-64/128 core in decrypt direction.

---
 rtl/blink_pkg.sv | 23 ++
 rtl/blink_res_fifo.sv | 62 ++++++
 rtl/blink_64_dec_ctrl.sv | 104 ++++++++++
 tb/tb_blink_64_dec_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared constants and types for the Blink-64/128 decrypt request controller.
// The block width, tweak width and core latency match the round-based core it drives.
package blink_pkg;

  localparam int N        = 64;
  localparam int TW       = 64;
  localparam int CORE_LAT = 14;
  localparam int FIFO_D   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } blink_state_e;

  localparam int CNT_W = $clog2(CORE_LAT);

  // Counter must hold CORE_LAT-1; keep at least one bit for degenerate latencies.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/blink_res_fifo.sv
// Small synchronous result FIFO with registered storage and first-word-fall-through head.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module blink_res_fifo
  import blink_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_empty;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Head is read straight from storage registers, so it never changes while not popped.
  assign o_valid = !w_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/blink_64_dec_ctrl.sv
// Request-side controller driving the Blink-64/128 core in decrypt direction:
// accepts one block, pulses the core load, waits the core latency, buffers the result.
module blink_64_dec_ctrl #(
  parameter int N        = blink_pkg::N,
  parameter int TW       = blink_pkg::TW,
  parameter int CORE_LAT = blink_pkg::CORE_LAT,
  parameter int FIFO_D   = blink_pkg::FIFO_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ct_valid,
  output logic          ct_ready,
  input  logic [N-1:0]  ct_data,
  input  logic [TW-1:0] ct_tweak,
  output logic          pt_valid,
  input  logic          pt_ready,
  output logic [N-1:0]  pt_data,
  output logic          core_rst,
  output logic          core_enc,
  output logic [N-1:0]  core_P,
  output logic [TW-1:0] core_T,
  input  logic [N-1:0]  core_C,
  output logic          busy
);

  import blink_pkg::*;

  localparam int CNT_BITS = cnt_width(CORE_LAT);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(CORE_LAT - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_RUN  = RUN;

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [CNT_BITS-1:0] r_cnt;
  logic [N-1:0]        r_core_p;
  logic [TW-1:0]       r_core_t;
  logic                w_accept;
  logic                w_push;
  logic                w_fifo_full;

  // No block is in flight while IDLE, so a free FIFO slot is enough to accept;
  // the result of the accepted block then always has room when it is pushed.
  assign ct_ready = rst && (r_state == ST_IDLE) && !w_fifo_full;
  assign w_accept = ct_valid && ct_ready;
  assign w_push   = (r_state == ST_RUN) && (r_cnt == '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = ST_RUN;
      ST_RUN:  if (r_cnt == '0) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_LOAD) begin
        r_cnt <= CNT_LOAD;
      end else if ((r_state == ST_RUN) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_core_p <= '0;
      r_core_t <= '0;
    end else if (w_accept) begin
      r_core_p <= ct_data;
      r_core_t <= ct_tweak;
    end
  end

  assign core_rst = (r_state == ST_LOAD);
  assign core_enc = 1'b0;
  assign core_P   = r_core_p;
  assign core_T   = r_core_t;
  assign busy     = (r_state == ST_LOAD) || (r_state == ST_RUN);

  blink_res_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (N)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (core_C),
    .i_pop   (pt_ready),
    .o_full  (w_fifo_full),
    .o_valid (pt_valid),
    .o_data  (pt_data)
  );

endmodule

// File: tb/tb_blink_64_dec_ctrl.sv
// Self-checking bench for blink_64_dec_ctrl: a toy core (C = P ^ T after CORE_LAT cycles),
// a request/result scoreboard, a vector table and hand-written corner sequences.
module tb_blink_64_dec_ctrl;

  localparam int CORE_LAT = 14;
  localparam int LAT      = CORE_LAT + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ct_valid;
  logic        ct_ready;
  logic [63:0] ct_data;
  logic [63:0] ct_tweak;
  logic        pt_valid;
  logic        pt_ready;
  logic [63:0] pt_data;
  logic        core_rst;
  logic        core_enc;
  logic [63:0] core_P;
  logic [63:0] core_T;
  logic [63:0] core_C;
  logic        busy;

  always #5 clk = ~clk;

  blink_64_dec_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .ct_data  (ct_data),
    .ct_tweak (ct_tweak),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .pt_data  (pt_data),
    .core_rst (core_rst),
    .core_enc (core_enc),
    .core_P   (core_P),
    .core_T   (core_T),
    .core_C   (core_C),
    .busy     (busy)
  );

  // Toy core: result is only presented in the single cycle CORE_LAT after the load pulse.
  logic [63:0] m_val   = '0;
  int          m_age   = 0;
  bit          m_armed = 1'b0;

  always @(posedge clk) begin
    if (core_rst) begin
      m_val   <= core_P ^ core_T;
      m_age   <= 1;
      m_armed <= 1'b1;
    end else if (m_armed && m_age < 1000) begin
      m_age <= m_age + 1;
    end
  end

  assign core_C = (m_armed && m_age == CORE_LAT) ? m_val
                                                 : (64'hA5A5_0F0F_5A5A_F0F0 ^ {32'd0, m_age});

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_acc  = 0;
  int          n_out  = 0;
  int          n_load = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (ct_valid && ct_ready) begin
        exp_q.push_back(ct_data ^ ct_tweak);
        n_acc++;
      end
      if (core_rst) begin
        n_load++;
        chk("core_enc", 64'(core_enc), 64'd0);
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(pt_valid), 64'd1);
        chk("hold_data", pt_data, prev_data);
      end
      if (pt_valid && pt_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", 64'(exp_q.size()), 64'd1);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("result_data", pt_data, e);
        end
        n_out++;
        $display("result #%0d data=%h cycle=%0d", n_out, pt_data, cyc);
      end
      prev_stall = pt_valid && !pt_ready;
      prev_data  = pt_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] c, input logic [63:0] t, output int acc_cyc);
    bit ok;
    ok       = 1'b0;
    ct_data  = c;
    ct_tweak = t;
    ct_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ct_ready) begin
        ok = 1'b1;
        break;
      end
    end
    acc_cyc = cyc;
    $display("request ct=%h tw=%h accepted=%0d cycle=%0d", c, t, ok, acc_cyc);
    @(posedge clk);
    #1;
    ct_valid = 1'b0;
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_valid(input int bound, output int at_cyc);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (pt_valid) begin
        ok = 1'b1;
        break;
      end
    end
    at_cyc = cyc;
    chk("valid_timeout", 64'(ok), 64'd1);
  endtask

  typedef struct {
    logic [63:0] ct;
    logic [63:0] tw;
    logic [63:0] pt;
  } vec_t;

  vec_t tbl [6];
  bit   rnd_done = 1'b0;

  initial begin
    int ka, kv, kb, kc, base_acc, base_out, base_load;
    int acc [4];
    bit flag;

    tbl[0] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 64'hFEDC_4567_7654_CDEF};
    tbl[1] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[3] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4] = '{64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_0000};
    tbl[5] = '{64'h8000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000};

    rst      = 1'b1;
    ct_valid = 1'b0;
    ct_data  = '0;
    ct_tweak = '0;
    pt_ready = 1'b0;

    // Power-on reset values.
    #2 rst = 1'b0;
    #1;
    chk("rst_ct_ready", 64'(ct_ready), 64'd0);
    chk("rst_pt_valid", 64'(pt_valid), 64'd0);
    chk("rst_core_rst", 64'(core_rst), 64'd0);
    chk("rst_core_enc", 64'(core_enc), 64'd0);
    chk("rst_core_P", core_P, 64'd0);
    chk("rst_core_T", core_T, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step();
    chk("idle_ct_ready", 64'(ct_ready), 64'd1);

    // Vector table: one block at a time, result value and accept-to-valid latency.
    pt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].ct, tbl[i].tw, ka);
      wait_valid(40, kv);
      chk("tbl_data", pt_data, tbl[i].pt);
      chk("tbl_latency", 64'(kv - ka), 64'(LAT));
      step();
    end

    // Back-to-back requests: spacing, load pulse count.
    base_load = n_load;
    for (int i = 0; i < 4; i++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, acc[i]);
    end
    for (int i = 1; i < 4; i++) begin
      chk("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'(LAT));
    end
    repeat (20) step();
    chk("b2b_loads", 64'(n_load - base_load), 64'd4);
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: two results buffered, then nothing more accepted until drained.
    pt_ready = 1'b0;
    base_acc = n_acc;
    base_out = n_out;
    fork
      begin
        int k;
        for (int i = 0; i < 4; i++) send({$urandom, $urandom}, {$urandom, $urandom}, k);
      end
      begin
        repeat (60) step();
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (ct_ready) flag = 1'b1;
        end
        chk("bp_accepts", 64'(n_acc - base_acc), 64'd2);
        chk("bp_ready_low", 64'(flag), 64'd0);
        chk("bp_valid", 64'(pt_valid), 64'd1);
        @(posedge clk);
        #1 pt_ready = 1'b1;
      end
    join
    for (int i = 0; i < 100 && (n_out - base_out) < 4; i++) step();
    chk("bp_outputs", 64'(n_out - base_out), 64'd4);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Hold: result stalled for ten cycles must not change.
    pt_ready = 1'b0;
    send(64'h1122_3344_5566_7788, 64'h0000_0000_FFFF_FFFF, ka);
    wait_valid(40, kv);
    repeat (10) step();
    chk("hold_final", pt_data, 64'h1122_3344_AA99_8877);
    pt_ready = 1'b1;
    step();
    step();

    // Push and pop in the same cycle: occupancy stays one.
    pt_ready = 1'b0;
    base_out = n_out;
    send(64'hAAAA_0000_0000_0001, 64'd0, ka);
    wait_valid(40, kv);
    step();
    send(64'hBBBB_0000_0000_0002, 64'd0, kb);
    while (cyc < kb + LAT - 1) step();
    pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    @(negedge clk);
    chk("sim_valid", 64'(pt_valid), 64'd1);
    chk("sim_head", pt_data, 64'hBBBB_0000_0000_0002);
    @(posedge clk);
    #1 pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    @(negedge clk);
    chk("sim_empty", 64'(pt_valid), 64'd0);
    chk("sim_outputs", 64'(n_out - base_out), 64'd2);
    step();

    // Reset while the core is running (counter at 5).
    pt_ready = 1'b1;
    send(64'h0F0F_0F0F_0F0F_0F0F, 64'h1234_5678_9ABC_DEF0, kc);
    while (cyc < kc + 10) step();
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_ct_ready", 64'(ct_ready), 64'd0);
    chk("mid_pt_valid", 64'(pt_valid), 64'd0);
    chk("mid_core_rst", 64'(core_rst), 64'd0);
    chk("mid_core_enc", 64'(core_enc), 64'd0);
    chk("mid_core_P", core_P, 64'd0);
    chk("mid_core_T", core_T, 64'd0);
    chk("mid_busy_rst", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (3) step();
    rst = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (pt_valid || core_rst) flag = 1'b1;
    end
    chk("mid_quiet", 64'(flag), 64'd0);
    step();
    send(64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, ka);
    wait_valid(40, kv);
    chk("mid_next_data", pt_data, 64'hFEDC_4567_7654_CDEF);
    chk("mid_next_latency", 64'(kv - ka), 64'(LAT));
    step();

    // Randomized traffic with random consumer stalls against the scoreboard.
    base_acc = n_acc;
    base_out = n_out;
    fork
      begin
        int k;
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) step();
          send({$urandom, $urandom}, {$urandom, $urandom}, k);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          step();
          pt_ready = 1'($urandom_range(0, 1));
        end
        pt_ready = 1'b1;
      end
    join
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    chk("rnd_drained", 64'(exp_q.size()), 64'd0);
    chk("rnd_accepts", 64'(n_acc - base_acc), 64'd24);
    chk("rnd_outputs", 64'(n_out - base_out), 64'd24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
